// File: rtl/replace_order_encoder_pkg.sv
// Shared ITCH transmit definitions: Replace Order ('U') constants, field layout, serializer states.
package replace_order_encoder_pkg;

  localparam logic [7:0]  ITCH_TYPE_REPLACE   = 8'h55;
  localparam int unsigned ITCH_LEN_REPLACE    = 27;
  localparam logic [3:0]  ITCH_PARSED_REPLACE = 4'd4;

  typedef struct packed {
    logic [63:0] old_ref;
    logic [63:0] new_ref;
    logic [31:0] shares;
    logic [31:0] price;
  } itch_replace_fields_t;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    SEND
  } tx_state_e;

  // Bytes 1..26 of the wire image; byte 0 (type) is inserted by the serializer.
  function automatic logic [7:0] replace_byte(input itch_replace_fields_t f,
                                              input logic [4:0]           idx);
    logic [207:0] body;
    logic [7:0]   b;
    body = {f, 16'h0000};
    b    = 8'h00;
    for (int unsigned k = 1; k <= 26; k++) begin
      if (idx == 5'(k)) b = body[215 - 8*k -: 8];
    end
    return b;
  endfunction

endpackage

// File: rtl/replace_order_encoder_tx_stage.sv
// Generic one-deep valid/ready holding register; frees on take_i, refills from the input handshake.
module replace_order_encoder_tx_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  input  logic         take_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready_o = !full_q;
  assign full_o     = full_q;
  assign data_o     = data_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (take_i) full_d = 1'b0;
    if (in_valid_i && !full_q) begin
      full_d = 1'b1;
      data_d = in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/replace_order_encoder.sv
// ITCH Replace Order ('U') transmit encoder: stages one field set and serializes it
// as a contiguous 27-byte big-endian stream with registered outputs.
module replace_order_encoder
  import replace_order_encoder_pkg::*;
#(
  parameter logic [7:0]  MSG_TYPE   = ITCH_TYPE_REPLACE,
  parameter int unsigned MSG_LENGTH = ITCH_LEN_REPLACE,
  parameter int unsigned MIN_GAP    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_old_order_ref,
  input  logic [63:0] in_new_order_ref,
  input  logic [31:0] in_shares,
  input  logic [31:0] in_price,
  input  logic        tx_enable,
  output logic [7:0]  byte_out,
  output logic        valid_out,
  output logic        sop,
  output logic        eop,
  output logic        busy,
  output logic [15:0] msg_count
);

  localparam logic [4:0] LAST_IDX = 5'(MSG_LENGTH - 1);
  localparam logic [3:0] GAP_LAST = 4'(MIN_GAP - 1);

  itch_replace_fields_t in_fields, stage_data, fields_q, fields_d;
  logic                 stage_full, take;
  tx_state_e            state_q, state_d;
  logic [4:0]           idx_q, idx_d;
  logic [3:0]           gap_q, gap_d;
  logic [7:0]           byte_q, byte_d;
  logic                 valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic [15:0]          count_q, count_d;

  assign in_fields = '{old_ref: in_old_order_ref, new_ref: in_new_order_ref,
                       shares: in_shares, price: in_price};

  replace_order_encoder_tx_stage #(.W($bits(itch_replace_fields_t))) u_stage (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_fields),
    .take_i     (take),
    .full_o     (stage_full),
    .data_o     (stage_data)
  );

  // The load cycle already emits byte 0, so SEND walks indices 1..26 and a
  // back-to-back start happens from IDLE on the cycle after byte 26.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    fields_d = fields_q;
    count_d  = count_q;
    byte_d   = '0;
    valid_d  = 1'b0;
    sop_d    = 1'b0;
    eop_d    = 1'b0;
    take     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (stage_full && tx_enable) begin
          take     = 1'b1;
          fields_d = stage_data;
          byte_d   = MSG_TYPE;
          valid_d  = 1'b1;
          sop_d    = 1'b1;
          idx_d    = 5'd1;
          state_d  = SEND;
        end
      end
      SEND: begin
        byte_d  = replace_byte(fields_q, idx_q);
        valid_d = 1'b1;
        idx_d   = idx_q + 5'd1;
        if (idx_q == LAST_IDX) begin
          eop_d   = 1'b1;
          count_d = count_q + 16'd1;
          idx_d   = '0;
          gap_d   = '0;
          state_d = (MIN_GAP > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      gap_q    <= '0;
      fields_q <= '0;
      count_q  <= '0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      fields_q <= fields_d;
      count_q  <= count_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
    end
  end

  assign byte_out  = byte_q;
  assign valid_out = valid_q;
  assign sop       = sop_q;
  assign eop       = eop_q;
  assign msg_count = count_q;
  assign busy      = (state_q != IDLE) || stage_full;

endmodule

// File: tb/tb_replace_order_encoder.sv
// Bench for replace_order_encoder: queue-based byte model with per-cycle compare, loopback
// field decode, plus directed latency/gap/reset scenarios.
module tb_replace_order_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, tx_enable, valid_out, sop, eop, busy;
  logic [63:0] in_old, in_new;
  logic [31:0] in_shares, in_price;
  logic [7:0]  byte_out;
  logic [15:0] msg_count;
  logic        g_in_valid, g_in_ready, g_valid_out, g_sop, g_eop, g_busy;
  logic [7:0]  g_byte;
  logic [15:0] g_count;

  always #5 clk = ~clk;

  replace_order_encoder #(.MIN_GAP(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_old_order_ref(in_old), .in_new_order_ref(in_new),
    .in_shares(in_shares), .in_price(in_price), .tx_enable(tx_enable),
    .byte_out(byte_out), .valid_out(valid_out), .sop(sop), .eop(eop),
    .busy(busy), .msg_count(msg_count)
  );

  replace_order_encoder #(.MIN_GAP(3)) dut_g (
    .clk(clk), .rst(rst), .in_valid(g_in_valid), .in_ready(g_in_ready),
    .in_old_order_ref(in_old), .in_new_order_ref(in_new),
    .in_shares(in_shares), .in_price(in_price), .tx_enable(tx_enable),
    .byte_out(g_byte), .valid_out(g_valid_out), .sop(g_sop), .eop(g_eop),
    .busy(g_busy), .msg_count(g_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0] o;
    logic [63:0] n;
    logic [31:0] s;
    logic [31:0] p;
  } fs_t;

  fs_t         q[$];
  int          pos = 0;
  logic [15:0] exp_count = '0;
  logic        txen_edge = 1'b0;
  logic [7:0]  log_bytes[27];
  int          cyc = 0, sop_cyc = 0, eop_cyc = 0;
  int          run = 0, max_run = 0, decoded = 0;
  int          g_idle = 0, gap_checks = 0;
  logic        g_seen_eop = 1'b0;
  logic [63:0] dec_o, dec_n;
  logic [31:0] dec_s, dec_p;

  function automatic logic [7:0] model_byte(input fs_t f, input int k);
    logic [63:0] t;
    t = 64'h0;
    if (k == 0)       t = 64'h55;
    else if (k <= 8)  t = f.o >> (8 * (8 - k));
    else if (k <= 16) t = f.n >> (8 * (16 - k));
    else if (k <= 20) t = {32'h0, f.s} >> (8 * (20 - k));
    else if (k <= 24) t = {32'h0, f.p} >> (8 * (24 - k));
    return t[7:0];
  endfunction

  // Compare on the falling edge: outputs reflect the previous rising edge, then
  // the model absorbs whatever the next rising edge will see.
  always @(negedge clk) begin
    cyc++;
    if (valid_out) begin
      run++;
      if (run > max_run) max_run = run;
      if (q.size() == 0) begin
        check("byte_without_msg", valid_out, 1'b0);
      end else begin
        check("byte", byte_out, model_byte(q[0], pos));
        check("sop", sop, pos == 0);
        check("eop", eop, pos == 26);
        if (pos == 0) begin
          check("start_without_txen", sop & ~txen_edge, 1'b0);
          sop_cyc = cyc;
        end
        log_bytes[pos] = byte_out;
        if (pos == 26) begin
          dec_o = '0; dec_n = '0; dec_s = '0; dec_p = '0;
          for (int k = 1;  k <= 8;  k++) dec_o = {dec_o[55:0], log_bytes[k]};
          for (int k = 9;  k <= 16; k++) dec_n = {dec_n[55:0], log_bytes[k]};
          for (int k = 17; k <= 20; k++) dec_s = {dec_s[23:0], log_bytes[k]};
          for (int k = 21; k <= 24; k++) dec_p = {dec_p[23:0], log_bytes[k]};
          check("loop_type", log_bytes[0], 8'h55);
          check("loop_old", dec_o, q[0].o);
          check("loop_new", dec_n, q[0].n);
          check("loop_shares", dec_s, q[0].s);
          check("loop_price", dec_p, q[0].p);
          decoded++;
          void'(q.pop_front());
          pos = 0;
          exp_count = exp_count + 16'd1;
          eop_cyc = cyc;
        end else begin
          pos++;
        end
      end
    end else begin
      run = 0;
      check("idle_outputs", {byte_out, sop, eop}, 10'h0);
      if (pos != 0) check("gap_in_message", valid_out, 1'b1);
    end
    check("msg_count", msg_count, exp_count);
    check("busy", busy, q.size() != 0);
    check("in_ready", in_ready, (q.size() - ((pos != 0) ? 1 : 0)) == 0);

    if (g_valid_out) begin
      if (g_sop && g_seen_eop) begin
        check("min_gap", g_idle, 3);
        gap_checks++;
      end
      g_idle = 0;
      if (g_eop) g_seen_eop = 1'b1;
    end else begin
      g_idle++;
    end

    txen_edge = tx_enable;
    if (rst) begin
      q.delete();
      pos = 0;
      exp_count = '0;
      g_seen_eop = 1'b0;
    end else if (in_valid && in_ready) begin
      q.push_back('{in_old, in_new, in_shares, in_price});
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    g_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Present a field set to DUT (sel=0) or gap DUT (sel=1) until it is taken.
  task automatic send(input bit sel, input logic [63:0] o, input logic [63:0] n,
                      input logic [31:0] s, input logic [31:0] p, input bit hold,
                      output int acc_cyc);
    logic took;
    took = 1'b0;
    in_old = o; in_new = n; in_shares = s; in_price = p;
    if (sel) g_in_valid = 1'b1; else in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      took = sel ? g_in_ready : in_ready;
      @(posedge clk);
      #1;
      if (took) break;
    end
    if (!took) check("accept_timeout", took, 1'b1);
    acc_cyc = cyc;
    if (!hold) begin
      in_valid = 1'b0;
      g_in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk);
      #1;
      done = !busy && !valid_out && !g_busy && !g_valid_out;
    end
    if (!done) check("drain_timeout", busy | valid_out | g_busy | g_valid_out, 1'b0);
  endtask

  task automatic wait_sop();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = sop;
    end
    if (!seen) check("sop_timeout", sop, 1'b1);
  endtask

  int acc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; g_in_valid = 1'b0; tx_enable = 1'b0;
    in_old = '0; in_new = '0; in_shares = '0; in_price = '0;
    do_reset();
    check("rst_valid", valid_out, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_count", msg_count, 16'h0);

    // single message with known bytes
    tx_enable = 1'b1;
    send(0, 64'h0102030405060708, 64'h1112131415161718, 32'h000003E8, 32'h0001E240, 0, acc);
    wait_idle();
    check("t1_sop_latency", sop_cyc, acc + 2);
    check("t1_sop_to_eop", eop_cyc - sop_cyc, 26);
    check("t1_b0", log_bytes[0], 8'h55);
    check("t1_b8", log_bytes[8], 8'h08);
    check("t1_b9", log_bytes[9], 8'h11);
    check("t1_b20", log_bytes[20], 8'hE8);
    check("t1_b23", log_bytes[23], 8'hE2);
    check("t1_b26", log_bytes[26], 8'h00);
    check("t1_count", msg_count, 16'd1);

    // three back-to-back with in_valid held
    do_reset();
    max_run = 0;
    send(0, 64'hA0A1A2A3A4A5A6A7, 64'hB0B1B2B3B4B5B6B7, 32'hC0C1C2C3, 32'hD0D1D2D3, 1, acc);
    send(0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 32'hFFFFFFFF, 32'h0, 1, acc);
    check("t2_ready_low", in_ready, 1'b0);
    send(0, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 32'h00000001, 32'h80000000, 0, acc);
    wait_idle();
    check("t2_contig", max_run, 81);
    check("t2_count", msg_count, 16'd3);

    // tx_enable gating and mid-message independence
    do_reset();
    tx_enable = 1'b0;
    send(0, 64'h1111, 64'h2222, 32'h3333, 32'h4444, 0, acc);
    repeat (5) @(posedge clk);
    #1;
    check("t3_no_valid", valid_out, 1'b0);
    check("t3_busy", busy, 1'b1);
    check("t3_ready", in_ready, 1'b0);
    tx_enable = 1'b1;
    wait_sop();
    repeat (10) @(posedge clk);
    #1 tx_enable = 1'b0;
    send(0, 64'h5555, 64'h6666, 32'h7777, 32'h8888, 0, acc);
    repeat (40) @(posedge clk);
    #1;
    check("t3_second_held", valid_out, 1'b0);
    check("t3_first_done", msg_count, 16'd1);
    tx_enable = 1'b1;
    wait_idle();
    check("t3_count", msg_count, 16'd2);

    // minimum gap on the MIN_GAP=3 instance
    do_reset();
    send(1, 64'h0A, 64'h0B, 32'h0C, 32'h0D, 1, acc);
    send(1, 64'h1A, 64'h1B, 32'h1C, 32'h1D, 0, acc);
    wait_idle();
    check("t4_gap_seen", gap_checks, 1);
    check("t4_count", g_count, 16'd2);

    // reset mid-message at byte 12
    do_reset();
    send(0, 64'hDEADBEEFCAFEF00D, 64'h0, 32'h12345678, 32'h9ABCDEF0, 0, acc);
    wait_sop();
    send(0, 64'h99, 64'h98, 32'h97, 32'h96, 0, acc);
    repeat (11) @(posedge clk);
    #1;
    check("t5_at_byte12", byte_out, 8'h00);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_valid", valid_out, 1'b0);
    check("t5_count", msg_count, 16'd0);
    check("t5_ready", in_ready, 1'b1);
    check("t5_busy", busy, 1'b0);
    send(0, 64'h0102030405060708, 64'h1112131415161718, 32'h000003E8, 32'h0001E240, 0, acc);
    wait_idle();
    check("t5_fresh_count", msg_count, 16'd1);

    // every completed message on the main instance was decoded back
    check("t6_decoded", decoded, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
